// File: rtl/miner_host_link_if.sv
// Host-side bus of miner_host_link: header load, digest readout and core hand-off.
// The slave modport is the link block; the master modport is the host/core side.
interface miner_host_link_if #(
  parameter int WORD_W    = 16,
  parameter int HDR_WORDS = 40,
  parameter int DIG_BYTES = 32,
  parameter int ADDR_W    = 6
);
  logic [WORD_W-1:0]           wr_data;
  logic                        host_ack;
  logic                        abort;
  logic                        core_done;
  logic [8*DIG_BYTES-1:0]      digest;
  logic                        rq;
  logic [ADDR_W-1:0]           addr;
  logic                        done;
  logic [7:0]                  rd_data;
  logic                        rd_oe;
  logic [WORD_W*HDR_WORDS-1:0] hdr;
  logic                        hdr_valid;

  modport slave (
    input  wr_data, host_ack, abort, core_done, digest,
    output rq, addr, done, rd_data, rd_oe, hdr, hdr_valid
  );

  modport master (
    output wr_data, host_ack, abort, core_done, digest,
    input  rq, addr, done, rd_data, rd_oe, hdr, hdr_valid
  );
endinterface

// File: rtl/miner_host_link.sv
// Host link for the mining core: loads the header word by word, starts the core, drains the digest bytewise.
// Optional MINER_NONCE_RELOAD_EN lets a FIN acknowledge with wr_data MSB set reload only the trailing nonce words.
module miner_host_link #(
  parameter int WORD_W      = 16,
  parameter int HDR_WORDS   = 40,
  parameter int DIG_BYTES   = 32,
  parameter int ADDR_W      = 6,
  parameter int NONCE_WORDS = 2
) (
  input logic              clk,
  input logic              rst_n,
  miner_host_link_if.slave bus
);
  localparam int HDR_BITS = WORD_W * HDR_WORDS;
  localparam int DIG_BITS = 8 * DIG_BYTES;

  localparam logic [2:0] S_LOAD       = 3'd0;
  localparam logic [2:0] S_LOAD_REL   = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_BUSY       = 3'd3;
  localparam logic [2:0] S_UNLOAD     = 3'd4;
  localparam logic [2:0] S_UNLOAD_REL = 3'd5;
  localparam logic [2:0] S_FIN        = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(HDR_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DIG_BYTES - 1);

  if ((2 ** ADDR_W) <= HDR_WORDS || (2 ** ADDR_W) <= DIG_BYTES) begin : g_bad_addr_w
    $error("ADDR_W too small for HDR_WORDS/DIG_BYTES");
  end
  if (NONCE_WORDS < 1 || NONCE_WORDS > HDR_WORDS) begin : g_bad_nonce
    $error("NONCE_WORDS out of range");
  end

  logic [2:0]          state;
  logic                ack_q;
  logic [ADDR_W-1:0]   addr;
  logic                rq;
  logic                done;
  logic                rd_oe;
  logic [7:0]          rd_data;
  logic [HDR_BITS-1:0] hdr;
  logic                hdr_valid;
  logic [DIG_BITS-1:0] dig;
  logic                ack_rise;

  // Byte 0 is the most significant byte of the digest.
  function automatic logic [7:0] byte_at(input logic [DIG_BITS-1:0] d, input logic [ADDR_W-1:0] idx);
    logic [DIG_BITS-1:0] s;
    s = d << (8 * idx);
    return s[DIG_BITS-1 -: 8];
  endfunction

  // Captures fire only on a fresh acknowledge, so a held host_ack writes once.
  assign ack_rise = bus.host_ack && !ack_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      ack_q     <= 1'b0;
      addr      <= '0;
      rq        <= 1'b0;
      done      <= 1'b0;
      rd_oe     <= 1'b0;
      rd_data   <= '0;
      hdr       <= '0;
      hdr_valid <= 1'b0;
      dig       <= '0;
    end else begin
      ack_q     <= bus.host_ack;
      hdr_valid <= 1'b0;
      if (bus.abort) begin
        state <= S_LOAD;
        addr  <= '0;
        done  <= 1'b0;
        rd_oe <= 1'b0;
        rq    <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            rq <= 1'b1;
            if (ack_rise) begin
              for (int k = 0; k < HDR_WORDS; k++) begin
                if (addr == ADDR_W'(k)) hdr[HDR_BITS-1-k*WORD_W -: WORD_W] <= bus.wr_data;
              end
              rq    <= 1'b0;
              state <= S_LOAD_REL;
            end
          end
          S_LOAD_REL: begin
            if (!bus.host_ack) begin
              if (addr == LAST_WORD) begin
                hdr_valid <= 1'b1;
                state     <= S_START;
              end else begin
                addr  <= addr + 1'b1;
                rq    <= 1'b1;
                state <= S_LOAD;
              end
            end
          end
          S_START: begin
            addr  <= '0;
            state <= S_BUSY;
          end
          S_BUSY: begin
            if (bus.core_done) begin
              dig     <= bus.digest;
              rd_data <= byte_at(bus.digest, '0);
              rq      <= 1'b1;
              done    <= 1'b1;
              rd_oe   <= 1'b1;
              state   <= S_UNLOAD;
            end
          end
          S_UNLOAD: begin
            if (ack_rise) begin
              rq    <= 1'b0;
              state <= S_UNLOAD_REL;
            end
          end
          S_UNLOAD_REL: begin
            if (!bus.host_ack) begin
              addr <= addr + 1'b1;
              if (addr == LAST_BYTE) begin
                rd_oe <= 1'b0;
                state <= S_FIN;
              end else begin
                rd_data <= byte_at(dig, addr + 1'b1);
                rq      <= 1'b1;
                state   <= S_UNLOAD;
              end
            end
          end
          S_FIN: begin
            // This acknowledge only restarts the job; it never writes a header word.
            if (ack_rise) begin
              done  <= 1'b0;
              rq    <= 1'b1;
              state <= S_LOAD;
`ifdef MINER_NONCE_RELOAD_EN
              addr  <= bus.wr_data[WORD_W-1] ? ADDR_W'(HDR_WORDS - NONCE_WORDS) : '0;
`else
              addr  <= '0;
`endif
            end
          end
          default: begin
            state <= S_LOAD;
            addr  <= '0;
            rq    <= 1'b1;
            done  <= 1'b0;
            rd_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rq        = rq;
  assign bus.addr      = addr;
  assign bus.done      = done;
  assign bus.rd_data   = rd_data;
  assign bus.rd_oe     = rd_oe;
  assign bus.hdr       = hdr;
  assign bus.hdr_valid = hdr_valid;
endmodule

// File: tb/tb_miner_host_link.sv
// Directed bench for miner_host_link: genesis load, digest readout, slow host, abort, reload, reset mid-unload.
module tb_miner_host_link;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   hv_cnt;
  int   hv_cyc;
  int   first_rq;

  logic [639:0] gen;
  logic [639:0] exp_hdr;
  logic [255:0] dig;

  miner_host_link_if #(.WORD_W(16), .HDR_WORDS(40), .DIG_BYTES(32), .ADDR_W(6)) bus ();

  miner_host_link #(.WORD_W(16), .HDR_WORDS(40), .DIG_BYTES(32), .ADDR_W(6), .NONCE_WORDS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.hdr_valid === 1'b1) begin
      hv_cnt++;
      hv_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic wait_rq(input logic lvl);
    int n;
    n = 0;
    while (bus.rq !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.rq !== lvl) chk("rq_timeout", bus.rq, lvl);
  endtask

  task automatic load_word(input int k, input logic [15:0] w);
    wait_rq(1'b1);
    chk("load_addr", bus.addr, k);
    bus.wr_data  = w;
    bus.host_ack = 1'b1;
    @(negedge clk);
    wait_rq(1'b0);
    bus.host_ack = 1'b0;
    exp_hdr[639-16*k -: 16] = w;
    @(negedge clk);
  endtask

  task automatic unload_byte(input int i, input logic [7:0] e);
    wait_rq(1'b1);
    chk("rd_addr", bus.addr, i);
    chk("rd_data", bus.rd_data, e);
    chk("rd_oe", bus.rd_oe, 1'b1);
    bus.host_ack = 1'b1;
    @(negedge clk);
    wait_rq(1'b0);
    chk("rd_hold", bus.rd_data, e);
    bus.host_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_core(input logic [255:0] d);
    bus.digest    = d;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rq", bus.rq, 1'b0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_oe", bus.rd_oe, 1'b0);
    chk("rst_hdr", bus.hdr, 0);
    chk("rst_hdr_valid", bus.hdr_valid, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; hv_cnt = 0; hv_cyc = 0; first_rq = 0;
    bus.wr_data = '0; bus.host_ack = 1'b0; bus.abort = 1'b0;
    bus.core_done = 1'b0; bus.digest = '0;
    exp_hdr = '0;
    gen = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
    for (int i = 0; i < 32; i++) dig[255-8*i -: 8] = 8'(i);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Genesis load with a zero-delay host
    wait_rq(1'b1);
    first_rq = cyc;
    for (int k = 0; k < 40; k++) load_word(k, gen[639-16*k -: 16]);
    chk("genesis_hdr", bus.hdr, gen);
    repeat (3) @(negedge clk);
    chk("hv_count", hv_cnt, 1);
    chk("hv_latency", hv_cyc - first_rq, 80);
    chk("busy_done", bus.done, 1'b0);
    chk("busy_rq", bus.rq, 1'b0);

    // Digest readout
    pulse_core(dig);
    chk("unl_done", bus.done, 1'b1);
    for (int i = 0; i < 32; i++) unload_byte(i, 8'(i));
    chk("fin_addr", bus.addr, 32);
    chk("fin_done", bus.done, 1'b1);
    chk("fin_rq", bus.rq, 1'b0);
    chk("fin_rd_oe", bus.rd_oe, 1'b0);

    // FIN restart, MSB set in wr_data
    bus.wr_data  = 16'h8000;
    bus.host_ack = 1'b1;
    @(negedge clk);
    chk("restart_done", bus.done, 1'b0);
    chk("restart_rq", bus.rq, 1'b1);
`ifdef MINER_NONCE_RELOAD_EN
    chk("nonce_addr", bus.addr, 38);
    bus.host_ack = 1'b0;
    @(negedge clk);
    load_word(38, 16'hA5A5);
    load_word(39, 16'h5A5A);
    chk("nonce_hdr", bus.hdr, exp_hdr);
    repeat (2) @(negedge clk);
    chk("nonce_hv", hv_cnt, 2);
    pulse_core(dig);
    for (int i = 0; i < 32; i++) unload_byte(i, 8'(i));
    bus.wr_data  = 16'h0000;
    bus.host_ack = 1'b1;
    @(negedge clk);
    chk("full_addr", bus.addr, 0);
`else
    chk("restart_addr", bus.addr, 0);
`endif
    bus.host_ack = 1'b0;
    @(negedge clk);
    chk("no_write_on_restart", bus.hdr, exp_hdr);

    // Slow host: ack held 7 cycles on word 5
    for (int k = 0; k < 5; k++) load_word(k, 16'h1000 + 16'(k));
    wait_rq(1'b1);
    bus.wr_data  = 16'hBEEF;
    bus.host_ack = 1'b1;
    @(negedge clk);
    bus.wr_data = 16'h1234;
    repeat (6) @(negedge clk);
    exp_hdr[639-16*5 -: 16] = 16'hBEEF;
    chk("slow_addr", bus.addr, 5);
    chk("slow_rq", bus.rq, 1'b0);
    chk("slow_hdr", bus.hdr, exp_hdr);
    bus.host_ack = 1'b0;
    @(negedge clk);
    chk("slow_addr_rel", bus.addr, 6);
    chk("slow_rq_rel", bus.rq, 1'b1);

    // Abort coincident with the ack of word 17
    for (int k = 6; k < 17; k++) load_word(k, 16'h1000 + 16'(k));
    wait_rq(1'b1);
    bus.wr_data  = 16'hDEAD;
    bus.host_ack = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.host_ack = 1'b0;
    chk("abort_addr", bus.addr, 0);
    chk("abort_rq", bus.rq, 1'b1);
    chk("abort_hdr", bus.hdr, exp_hdr);
    pulse_core({8{32'hFFFF_FFFF}});
    chk("ign_done", bus.done, 1'b0);
    chk("ign_rd_oe", bus.rd_oe, 1'b0);
    chk("ign_rq", bus.rq, 1'b1);
    chk("ign_addr", bus.addr, 0);

    // Full reload, then reset in the middle of the readout
    for (int k = 0; k < 40; k++) load_word(k, 16'h5A00 ^ (16'(k) * 16'h0101));
    chk("reload_hdr", bus.hdr, exp_hdr);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) dig[255-8*i -: 8] = 8'hF0 - 8'(i);
    pulse_core(dig);
    for (int i = 0; i < 12; i++) unload_byte(i, 8'hF0 - 8'(i));
    wait_rq(1'b1);
    chk("b12_data", bus.rd_data, 8'hE4);
    chk("b12_addr", bus.addr, 12);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rq", bus.rq, 1'b1);
    chk("post_rst_addr", bus.addr, 0);
    chk("post_rst_done", bus.done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/miner_host_link.md
# miner_host_link

Parametrised host interface for the mining datapath. It loads a block header of `HDR_WORDS` words of `WORD_W` bits from the host over a four-phase request/acknowledge handshake. It then starts the hash core and streams the resulting digest back one byte at a time, using the same handshake. It sits between the top-level pins and the hash core, replacing fixed 16-bit/40-word load logic with configurable widths, explicit acknowledge, abort, and optional nonce-only reload.

## Interface
- `WORD_W`, 16: host write word width in bits.
- `HDR_WORDS`, 40: words per header; `HDR_BITS = WORD_W*HDR_WORDS`.
- `DIG_BYTES`, 32: digest length in bytes.
- `ADDR_W`, 6: address width; requires `2**ADDR_W > max(HDR_WORDS, DIG_BYTES)`.
- `NONCE_WORDS`, 2: trailing header words rewritten on a nonce reload.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `wr_data` in `WORD_W`: host write word, sampled on acknowledge.
- `host_ack` in 1: host acknowledge/strobe, level-sensitive.
- `abort` in 1: synchronous job abort.
- `core_done` in 1: one-cycle pulse from the hash core; the digest is valid in that cycle.
- `digest` in `8*DIG_BYTES`: core result, MSB = byte 0.
- `rq` out 1: block requests a word (load) or presents a byte (unload).
- `addr` out `ADDR_W`: current word or byte index.
- `done` out 1: digest available or being drained.
- `rd_data` out 8: digest byte at `addr`.
- `rd_oe` out 1: high while `rd_data` is valid (host drives output enables from it).
- `hdr` out `HDR_BITS`: assembled header; word k occupies `hdr[HDR_BITS-1-k*WORD_W -: WORD_W]`.
- `hdr_valid` out 1: one-cycle start pulse to the core.

## Operation
- States: LOAD, LOAD_REL, START, BUSY, UNLOAD, UNLOAD_REL, FIN.
- **LOAD** (`rq`=1):
  - `host_ack`=1 writes `wr_data` into word `addr` of `hdr`, then goes to LOAD_REL (`rq`=0).
- **LOAD_REL**:
  - Waits for `host_ack`=0.
  - If `addr`=HDR_WORDS-1, goes to START; otherwise `addr`+1 and back to LOAD.
- **START**: `hdr_valid`=1 for exactly one cycle; `addr` resets to 0; goes to BUSY.
- **BUSY**:
  - `rq`=0, `done`=0.
  - `core_done` latches `digest` into an internal register and goes to UNLOAD.
  - `core_done` in any other state is ignored.
- **UNLOAD**:
  - `done`=1, `rd_oe`=1, `rq`=1.
  - `rd_data` = latched byte `addr`, i.e. `dig[8*DIG_BYTES-1-8*addr -: 8]`.
  - `host_ack`=1 goes to UNLOAD_REL (`rq`=0, `rd_data` held).
- **UNLOAD_REL**:
  - Waits for `host_ack`=0; then `addr`+1.
  - If the new `addr` equals DIG_BYTES, goes to FIN; otherwise back to UNLOAD.
- **FIN**:
  - `addr`=DIG_BYTES, `done`=1, `rd_oe`=0, `rq`=0.
  - A `host_ack` rising edge (sampled 0 then 1) goes to LOAD with `addr`=0 and `done`=0. That acknowledge is not a data write.
- **abort**:
  - Overrides every state; next state LOAD, `addr`=0, `done`=0, `hdr_valid`=0.
  - `hdr` contents are retained.
  - `abort` together with `host_ack` in LOAD discards the word.
- A held `host_ack` captures exactly once; a new capture requires release.
- `addr` never wraps. `WORD_W` has no width constraint beyond ≥1.

## Timing
- Reset: `rq`, `addr`, `done`, `rd_data`, `rd_oe`, `hdr`, `hdr_valid` all 0, and the digest register is cleared. The first cycle after `rst_n`=1 is LOAD with `rq`=1.
- All outputs are registered.
- `host_ack` sampled high at edge N: `hdr` word updated and `rq`=0 visible after N.
- `host_ack` sampled low at edge M: `addr`+1 and `rq`=1 visible after M.
- The fastest host completes one word or byte per 2 cycles.
- Last load release at edge M: `hdr_valid`=1 during cycle M+1 only; BUSY from M+2.
- `core_done` at edge K: UNLOAD with `rq`=1 and valid `rd_data` visible after K.
- Minimum full job: 2·HDR_WORDS + 2 + core latency + 2·DIG_BYTES cycles.
- Reset mid-operation returns to reset values regardless of state.

## Configuration
- `MINER_NONCE_RELOAD_EN` defined:
  - In FIN, a `host_ack` rising edge with `wr_data[WORD_W-1]`=1 enters LOAD with `addr`=HDR_WORDS-NONCE_WORDS. Only the trailing nonce words are rewritten; the rest of `hdr` is preserved.
  - With `wr_data[WORD_W-1]`=0, the block enters LOAD with `addr`=0.
- Not defined: FIN always restarts at `addr`=0. `NONCE_WORDS` is unused.

## Test plan
- **Genesis load:** after reset, load 40 words of header 0x0100…1DAC2B7C with a zero-delay host.
  - `hdr` equals the 640-bit value.
  - One `hdr_valid` pulse exactly 80 cycles after the first `rq`.
- **Digest readout:** `core_done` with `digest`=0x000102…1F.
  - Bytes 0x00..0x1F are read at `addr` 0..31.
  - Then `addr`=32, `done`=1, `rq`=0, `rd_oe`=0.
- **Slow host:** `host_ack` held 7 cycles on word 5 (0xBEEF) → exactly one capture; `addr` advances 5→6 only after release.
- **Abort:** `abort` at word 17 coincident with `host_ack`.
  - The word is dropped; next cycle `addr`=0, `rq`=1.
  - Words 0–16 are unchanged in `hdr`.
  - A `core_done` pulse during LOAD is ignored.
- **Nonce reload:** with `MINER_NONCE_RELOAD_EN`, FIN ack with MSB=1 → `addr`=38, only words 38–39 rewritten, then `hdr_valid`. Without the macro, `addr`=0.
- **Reset mid-unload:** `rst_n`=0 at byte 12 → all outputs 0; after release, `rq`=1 with `addr`=0 and `done`=0.
